// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types.
// Provides the machine word, the branch-prediction word that travels with an
// instruction from fetch into decode, and the 2-bit direction-counter states
// used by the branch predictor.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    // Prediction attached to the instruction entering decode.
    //   predicted    : the BTB hit for this PC (a prediction was made)
    //   prediction   : predicted direction (1 = taken)
    //   mp_valid     : misprediction field valid (set later in the pipe)
    //   mispredicted : misprediction flag (set later in the pipe)
    //   brp_target   : address fetch was redirected to
    //   brp_alt      : the address that was not chosen
    typedef struct packed {
        logic      predicted;
        logic      prediction;
        logic      mp_valid;
        logic      mispredicted;
        rv32i_word brp_target;
        rv32i_word brp_alt;
    } rv32i_brp_word;

    // 2-bit saturating direction counter; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        snt = 2'b00,
        wnt = 2'b01,
        wt  = 2'b10,
        st  = 2'b11
    } bht_state_t;

    localparam bht_state_t BHT_RESET_STATE = wnt;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: next-state logic of one 2-bit saturating direction counter.
// Ports:
//   cur_state  : current counter value
//   taken      : resolved direction (1 = taken)
//   next_state : counter value after training on this resolution
module sat_counter2
    import rv32i_types::*;
(
    input  bht_state_t cur_state,
    input  logic       taken,
    output bht_state_t next_state
);

    // Step toward the resolved direction, saturating at both ends.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            snt:     next_state = taken ? wnt : snt;
            wnt:     next_state = taken ? wt  : snt;
            wt:      next_state = taken ? st  : wnt;
            st:      next_state = taken ? st  : wt;
            default: next_state = BHT_RESET_STATE;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BHT (2-bit counters) + BTB next-PC predictor.
// Lookup is combinational on fetch_pc; the prediction is registered into
// brp_out for the instruction entering decode. Execute resolutions train the
// counter and (when taken) write the BTB; updates become visible next cycle.
// Ports:
//   clk, rst            : clock, async active-high reset
//   fetch_pc/valid      : PC fetched this cycle
//   stall, flush        : hold / kill the brp_out register (flush wins)
//   next_pc             : predicted next fetch address (combinational)
//   brp_out             : registered prediction word
//   res_*               : resolution from execute
//   br_count, mp_count  : resolved-branch and misprediction counters
module branch_predictor
    import rv32i_types::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   fetch_pc,
    input  logic          fetch_valid,
    input  logic          stall,
    input  logic          flush,
    output logic [31:0]   next_pc,
    output rv32i_brp_word brp_out,
    input  logic          res_valid,
    input  logic [31:0]   res_pc,
    input  logic          res_taken,
    input  logic [31:0]   res_target,
    input  logic          res_mispredicted,
    output logic [31:0]   br_count,
    output logic [31:0]   mp_count
);

    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = 30 - IDX_BITS;

    // Table state
    bht_state_t            bht_q        [ENTRIES];
    bht_state_t            bht_d        [ENTRIES];
    logic [ENTRIES-1:0]    btb_valid_q;
    logic [ENTRIES-1:0]    btb_valid_d;
    logic [TAG_BITS-1:0]   btb_tag_q    [ENTRIES];
    logic [TAG_BITS-1:0]   btb_tag_d    [ENTRIES];
    logic [31:0]           btb_target_q [ENTRIES];
    logic [31:0]           btb_target_d [ENTRIES];

    rv32i_brp_word         brp_out_q;
    rv32i_brp_word         brp_out_d;
    logic [31:0]           br_count_q;
    logic [31:0]           br_count_d;
    logic [31:0]           mp_count_q;
    logic [31:0]           mp_count_d;

    // Lookup / update decode
    logic [IDX_BITS-1:0]   fetch_idx_s;
    logic [TAG_BITS-1:0]   fetch_tag_s;
    logic [IDX_BITS-1:0]   res_idx_s;
    logic [TAG_BITS-1:0]   res_tag_s;
    logic                  hit_s;
    logic                  taken_pred_s;
    logic [31:0]           seq_pc_s;
    logic [31:0]           btb_tgt_s;
    logic [31:0]           pred_pc_s;
    logic [31:0]           alt_pc_s;
    bht_state_t            res_ctr_s;
    bht_state_t            res_ctr_next_s;

    assign fetch_idx_s = fetch_pc[IDX_BITS+1:2];
    assign fetch_tag_s = fetch_pc[31:IDX_BITS+2];
    assign res_idx_s   = res_pc[IDX_BITS+1:2];
    assign res_tag_s   = res_pc[31:IDX_BITS+2];
    assign res_ctr_s   = bht_q[res_idx_s];

    // One shared counter next-state block: only one entry trains per cycle.
    sat_counter2 u_sat_counter2 (
        .cur_state  (res_ctr_s),
        .taken      (res_taken),
        .next_state (res_ctr_next_s)
    );

    // Combinational lookup on registered tables (no bypass of this cycle's update).
    always_comb begin
        seq_pc_s     = fetch_pc + 32'd4;
        btb_tgt_s    = btb_target_q[fetch_idx_s];
        hit_s        = btb_valid_q[fetch_idx_s] && (btb_tag_q[fetch_idx_s] == fetch_tag_s);
        taken_pred_s = hit_s && bht_q[fetch_idx_s][1];
        pred_pc_s    = seq_pc_s;
        alt_pc_s     = seq_pc_s;
        if (taken_pred_s) begin
            pred_pc_s = btb_tgt_s;
            alt_pc_s  = seq_pc_s;
        end else if (hit_s) begin
            pred_pc_s = seq_pc_s;
            alt_pc_s  = btb_tgt_s;
        end else begin
            pred_pc_s = seq_pc_s;
            alt_pc_s  = seq_pc_s;
        end
    end

    // Sequential fetch while reset is held, otherwise the prediction.
    always_comb begin
        if (rst) begin
            next_pc = seq_pc_s;
        end else begin
            next_pc = pred_pc_s;
        end
    end

    // Output register next state: flush beats stall beats load.
    always_comb begin
        brp_out_d = brp_out_q;
        if (flush) begin
            brp_out_d = '0;
        end else if (stall) begin
            brp_out_d = brp_out_q;
        end else if (fetch_valid) begin
            brp_out_d.predicted    = hit_s;
            brp_out_d.prediction   = taken_pred_s;
            brp_out_d.mp_valid     = 1'b0;
            brp_out_d.mispredicted = 1'b0;
            brp_out_d.brp_target   = pred_pc_s;
            brp_out_d.brp_alt      = alt_pc_s;
        end else begin
            brp_out_d = '0;
        end
    end

    // Table training. An aliasing PC takes over the entry but keeps its counter.
    always_comb begin
        bht_d        = bht_q;
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        if (res_valid) begin
            bht_d[res_idx_s] = res_ctr_next_s;
            if (res_taken) begin
                btb_valid_d[res_idx_s]  = 1'b1;
                btb_tag_d[res_idx_s]    = res_tag_s;
                btb_target_d[res_idx_s] = res_target;
            end else begin
                btb_valid_d[res_idx_s]  = btb_valid_q[res_idx_s];
            end
        end else begin
            bht_d = bht_q;
        end
    end

    // Statistics counters, wrapping naturally at 2^32.
    always_comb begin
        br_count_d = br_count_q;
        mp_count_d = mp_count_q;
        if (res_valid) begin
            br_count_d = br_count_q + 32'd1;
            if (res_mispredicted) begin
                mp_count_d = mp_count_q + 32'd1;
            end else begin
                mp_count_d = mp_count_q;
            end
        end else begin
            br_count_d = br_count_q;
        end
    end

    // Table state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i]        <= BHT_RESET_STATE;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= 32'd0;
            end
            btb_valid_q <= '0;
        end else begin
            bht_q        <= bht_d;
            btb_valid_q  <= btb_valid_d;
            btb_tag_q    <= btb_tag_d;
            btb_target_q <= btb_target_d;
        end
    end

    // Output and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brp_out_q  <= '0;
            br_count_q <= 32'd0;
            mp_count_q <= 32'd0;
        end else begin
            brp_out_q  <= brp_out_d;
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
        end
    end

    assign brp_out  = brp_out_q;
    assign br_count = br_count_q;
    assign mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    import rv32i_types::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   fetch_pc;
    logic          fetch_valid;
    logic          stall;
    logic          flush;
    logic [31:0]   next_pc;
    rv32i_brp_word brp_out;
    logic          res_valid;
    logic [31:0]   res_pc;
    logic          res_taken;
    logic [31:0]   res_target;
    logic          res_mispredicted;
    logic [31:0]   br_count;
    logic [31:0]   mp_count;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_br = 32'd0;
    logic [31:0] exp_mp = 32'd0;

    branch_predictor #(.IDX_BITS(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .fetch_valid      (fetch_valid),
        .stall            (stall),
        .flush            (flush),
        .next_pc          (next_pc),
        .brp_out          (brp_out),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .res_mispredicted (res_mispredicted),
        .br_count         (br_count),
        .mp_count         (mp_count)
    );

    always #5 clk = ~clk;

    function automatic rv32i_brp_word mk(input logic p, input logic pr,
                                         input logic [31:0] t, input logic [31:0] a);
        rv32i_brp_word w;
        w = '0;
        w.predicted  = p;
        w.prediction = pr;
        w.brp_target = t;
        w.brp_alt    = a;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a fetch and check the combinational next_pc.
    task automatic fetch_chk(input string nm, input logic [31:0] pc, input logic [31:0] exp_npc);
        fetch_pc    = pc;
        fetch_valid = 1'b1;
        #1;
        n_vec++;
        if (next_pc !== exp_npc) begin
            n_err++;
            $display("FAIL %s next_pc: got %h expected %h", nm, next_pc, exp_npc);
        end
    endtask

    task automatic brp_chk(input string nm, input rv32i_brp_word e);
        n_vec++;
        if (brp_out !== e) begin
            n_err++;
            $display("FAIL %s brp_out: got %h expected %h", nm, brp_out, e);
        end
    endtask

    task automatic cnt_chk(input string nm);
        n_vec++;
        if (br_count !== exp_br || mp_count !== exp_mp) begin
            n_err++;
            $display("FAIL %s counts: got br=%h mp=%h expected br=%h mp=%h",
                     nm, br_count, mp_count, exp_br, exp_mp);
        end
    endtask

    // One-cycle resolution with no fetch.
    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mp);
        fetch_valid      = 1'b0;
        res_valid        = 1'b1;
        res_pc           = pc;
        res_taken        = tk;
        res_target       = tgt;
        res_mispredicted = mp;
        tick();
        res_valid        = 1'b0;
        res_mispredicted = 1'b0;
        exp_br           = exp_br + 32'd1;
        if (mp) exp_mp = exp_mp + 32'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_pc = 32'h100; fetch_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        res_valid = 1'b0; res_pc = 32'd0; res_taken = 1'b0; res_target = 32'd0; res_mispredicted = 1'b0;
        #2;
        n_vec++;
        if (next_pc !== 32'h104) begin
            n_err++; $display("FAIL reset next_pc: got %h expected %h", next_pc, 32'h104);
        end
        tick(); tick();
        brp_chk("reset", '0);
        cnt_chk("reset");
        rst = 1'b0;
        fetch_valid = 1'b0;
        tick();
    endtask

    task automatic test_cold_fetch();
        fetch_chk("cold", 32'h100, 32'h104);
        tick();
        fetch_valid = 1'b0;
        brp_chk("cold", mk(1'b0, 1'b0, 32'h104, 32'h104));
    endtask

    task automatic test_train_taken();
        resolve(32'h100, 1'b1, 32'h200, 1'b1);
        fetch_chk("train", 32'h100, 32'h200);
        tick();
        fetch_valid = 1'b0;
        brp_chk("train", mk(1'b1, 1'b1, 32'h200, 32'h104));
        cnt_chk("train");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) resolve(32'h100, 1'b1, 32'h200, 1'b0);
        resolve(32'h100, 1'b0, 32'h0, 1'b1);      // 11 -> 10
        fetch_chk("sat_10", 32'h100, 32'h200);
        resolve(32'h100, 1'b0, 32'h0, 1'b0);      // 10 -> 01
        fetch_chk("sat_01", 32'h100, 32'h104);
        resolve(32'h100, 1'b0, 32'h0, 1'b0);      // 01 -> 00
        fetch_chk("sat_00", 32'h100, 32'h104);
        tick();
        fetch_valid = 1'b0;
        brp_chk("sat_00", mk(1'b1, 1'b0, 32'h104, 32'h200));
        resolve(32'h100, 1'b0, 32'h0, 1'b0);      // stays 00
        fetch_chk("sat_floor", 32'h100, 32'h104);
        fetch_valid = 1'b0;
        cnt_chk("sat");
    endtask

    task automatic test_same_cycle();
        resolve(32'h100, 1'b1, 32'h200, 1'b0);    // 00 -> 01
        res_valid = 1'b1; res_pc = 32'h100; res_taken = 1'b1; res_target = 32'h200;
        fetch_chk("same_old", 32'h100, 32'h104);  // 01 -> 10 not yet visible
        tick();
        res_valid = 1'b0;
        exp_br = exp_br + 32'd1;
        brp_chk("same_old", mk(1'b1, 1'b0, 32'h104, 32'h200));
        fetch_chk("same_new", 32'h100, 32'h200);
        tick();
        fetch_valid = 1'b0;
        brp_chk("same_new", mk(1'b1, 1'b1, 32'h200, 32'h104));
    endtask

    task automatic test_alias();
        fetch_chk("alias_miss", 32'h4100, 32'h4104);
        fetch_valid = 1'b0;
        resolve(32'h4100, 1'b1, 32'h300, 1'b0);   // shared counter 10 -> 11
        fetch_chk("alias_new", 32'h4100, 32'h300);
        fetch_chk("alias_old", 32'h100, 32'h104);
        tick();
        fetch_valid = 1'b0;
        brp_chk("alias_old", mk(1'b0, 1'b0, 32'h104, 32'h104));
        resolve(32'h4100, 1'b0, 32'h0, 1'b0);     // 11 -> 10, BTB untouched
        fetch_chk("alias_nt", 32'h4100, 32'h300);
        fetch_valid = 1'b0;
        cnt_chk("alias");
    endtask

    task automatic test_stall_flush();
        rv32i_brp_word held;
        held = mk(1'b1, 1'b1, 32'h300, 32'h4104);
        fetch_chk("sf_load", 32'h4100, 32'h300);
        tick();
        brp_chk("sf_load", held);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_pc = 32'h8 + 32'(i * 4);
            tick();
            brp_chk("sf_hold", held);
        end
        flush = 1'b1;
        tick();
        brp_chk("sf_flush_stall", '0);
        flush = 1'b0; stall = 1'b0;
        fetch_chk("sf_reload", 32'h4100, 32'h300);
        tick();
        fetch_valid = 1'b0;
        tick();
        brp_chk("sf_idle_clear", '0);
        fetch_valid = 1'b1; fetch_pc = 32'h4100; flush = 1'b1;
        tick();
        flush = 1'b0; fetch_valid = 1'b0;
        brp_chk("sf_flush_load", '0);
    endtask

    task automatic test_res_gating();
        res_valid = 1'b0; res_mispredicted = 1'b1;
        tick(); tick();
        res_mispredicted = 1'b0;
        cnt_chk("gating");
    endtask

    task automatic test_counter_wrap();
        force dut.mp_count_d = 32'hFFFF_FFFF;
        tick();
        release dut.mp_count_d;
        exp_mp = 32'hFFFF_FFFF;
        cnt_chk("wrap_preset");
        resolve(32'h40, 1'b0, 32'h0, 1'b1);
        cnt_chk("wrap");
    endtask

    task automatic test_reset_mid();
        fetch_pc = 32'h100; fetch_valid = 1'b1;
        res_valid = 1'b1; res_pc = 32'h100; res_taken = 1'b1; res_target = 32'h500;
        res_mispredicted = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (dut.bht_q[0] !== 2'b01 || dut.btb_valid_q !== 64'd0) begin
            n_err++;
            $display("FAIL rst_mid tables: got ctr=%b valid=%h expected ctr=01 valid=0",
                     dut.bht_q[0], dut.btb_valid_q);
        end
        n_vec++;
        if (next_pc !== 32'h104 || brp_out !== '0) begin
            n_err++;
            $display("FAIL rst_mid outputs: got next_pc=%h brp=%h expected 104 / 0", next_pc, brp_out);
        end
        tick();                                   // edge with resolution under reset
        res_valid = 1'b0; res_mispredicted = 1'b0; fetch_valid = 1'b0;
        rst = 1'b0;
        exp_br = 32'd0; exp_mp = 32'd0;
        tick();
        cnt_chk("rst_mid");
        brp_chk("rst_mid", '0);
        fetch_chk("rst_mid_a", 32'h100, 32'h104);
        fetch_chk("rst_mid_b", 32'h4100, 32'h4104);
        fetch_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_fetch();
        test_train_taken();
        test_saturate();
        test_same_cycle();
        test_alias();
        test_stall_flush();
        test_res_gating();
        test_counter_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
